// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: shared widths, frame length and register addresses for the SPI PWM register bank
package spi_pwm_pkg;
  localparam int CMD_W = 8;
  localparam int DATA_W = 32;
  localparam int FRAME_BITS = CMD_W + DATA_W;
  localparam int CMD_READ = 7;
  localparam logic [6:0] ADDR_CTRL = 7'h00;
  localparam logic [6:0] ADDR_HIGH = 7'h01;
  localparam logic [6:0] ADDR_FREQ = 7'h02;
  localparam logic [6:0] ADDR_STATUS = 7'h03;
  localparam logic [6:0] ADDR_VERSION = 7'h04;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser plus previous-value flop giving sync level and rise/fall pulses
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [2:0] s_q, s_d;
  always_comb s_d = {s_q[1:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= {3{RST_VAL}};
    else s_q <= s_d;
  assign sync = s_q[1];
  assign rise = s_q[1] & ~s_q[2];
  assign fall = ~s_q[1] & s_q[2];
endmodule

// File: rtl/spi_pwm_regs.sv
// spi_pwm_regs: oversampled SPI mode-0 slave register bank driving the PWM generator controls
module spi_pwm_regs
  import spi_pwm_pkg::*;
#(
  parameter logic [DATA_W-1:0] VERSION = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              start,
  output logic [DATA_W-1:0] cycles_high,
  output logic [DATA_W-1:0] cycles_freq
);
  logic sclk_s, sclk_rise, sclk_fall, cs_s, cs_rise, cs_fall, mosi_s, mosi_rise, mosi_fall;
  logic unused_ok;
  logic [5:0] cnt_q, cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d, high_q, high_d, freq_q, freq_d, rdata, wdata;
  logic [CMD_W-1:0] cmd_q, cmd_d, cmd_new;
  logic [1:0] settle_q, settle_d;
  logic err_q, err_d, start_q, start_d, frame_q, frame_d, armed_q, armed_d;
  spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .rst_n(rst_n), .d(cs_n), .sync(cs_s), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge u_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  assign unused_ok = ^{sclk_s, mosi_rise, mosi_fall};
  assign cmd_new = {rx_q[CMD_W-2:0], mosi_s};
  assign wdata = {rx_q, mosi_s};
  assign rdata = cmd_new[6:0] == ADDR_CTRL    ? {{(DATA_W-1){1'b0}}, start_q} :
                 cmd_new[6:0] == ADDR_HIGH    ? high_q :
                 cmd_new[6:0] == ADDR_FREQ    ? freq_q :
                 cmd_new[6:0] == ADDR_STATUS  ? {{(DATA_W-2){1'b0}}, err_q, start_q} :
                 cmd_new[6:0] == ADDR_VERSION ? VERSION : '0;
  always_comb begin
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    cmd_d = cmd_q;
    err_d = err_q;
    start_d = start_q;
    high_d = high_q;
    freq_d = freq_q;
    frame_d = frame_q;
    settle_d = &settle_q ? settle_q : settle_q + 2'd1;
    armed_d = armed_q | (&settle_q & cs_s);
    if (cs_fall & armed_q) begin
      frame_d = 1'b1;
      cnt_d = '0;
    end else if (cs_rise) begin
      frame_d = 1'b0;
      cnt_d = '0;
      err_d = err_q | (cnt_q != 6'd0 && cnt_q < 6'(FRAME_BITS));
    end else if (frame_q & sclk_rise & (cnt_q < 6'(FRAME_BITS))) begin
      rx_d = {rx_q[DATA_W-3:0], mosi_s};
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(CMD_W-1)) begin
        cmd_d = cmd_new;
        tx_d = cmd_new[CMD_READ] ? rdata : tx_q;
        err_d = cmd_new[CMD_READ] && cmd_new[6:0] == ADDR_STATUS ? 1'b0 : err_q;
      end
      if (cnt_q == 6'(FRAME_BITS-1) && !cmd_q[CMD_READ]) begin
        start_d = cmd_q[6:0] == ADDR_CTRL ? wdata[0] : start_q;
        high_d = cmd_q[6:0] == ADDR_HIGH ? wdata : high_q;
        freq_d = cmd_q[6:0] == ADDR_FREQ ? wdata : freq_q;
      end
    end else if (frame_q & sclk_fall & (cnt_q >= 6'(CMD_W+1)) & (cnt_q <= 6'(FRAME_BITS-1))) begin
      tx_d = tx_q << 1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      cmd_q <= '0;
      err_q <= 1'b0;
      start_q <= 1'b0;
      high_q <= '0;
      freq_q <= '0;
      frame_q <= 1'b0;
      settle_q <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      cmd_q <= cmd_d;
      err_q <= err_d;
      start_q <= start_d;
      high_q <= high_d;
      freq_q <= freq_d;
      frame_q <= frame_d;
      settle_q <= settle_d;
      armed_q <= armed_d;
    end
  assign miso = frame_q & cmd_q[CMD_READ] & (cnt_q >= 6'(CMD_W)) & tx_q[DATA_W-1];
  assign miso_oe = ~cs_s;
  assign start = start_q;
  assign cycles_high = high_q;
  assign cycles_freq = freq_q;
endmodule

// File: tb/tb_spi_pwm_regs.sv
// tb_spi_pwm_regs: directed self-checking bench for the SPI PWM register bank
module tb_spi_pwm_regs;
  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, start;
  logic [31:0] cycles_high, cycles_freq, rd;
  int total = 0, bad = 0;
  spi_pwm_regs dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .start(start),
    .cycles_high(cycles_high), .cycles_freq(cycles_freq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits, input int h, output logic [31:0] r);
    logic [39:0] f;
    f = {cmd, data};
    r = '0;
    cs_n = 1'b0;
    #(10 * h);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 40) ? f[39-i] : 1'b1;
      #(10 * h);
      sclk = 1'b1;
      #(10 * h);
      if (i >= 8 && i < 40) r = {r[30:0], miso};
      if (i == 8) chk("oe_in_frame", {31'b0, miso_oe}, 32'd1);
      sclk = 1'b0;
    end
    #(10 * h);
    cs_n = 1'b1;
  endtask
  task automatic gap();
    @(negedge clk);
    repeat (6) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", {31'b0, start}, 32'd0);
    chk("rst_high", cycles_high, 32'd0);
    chk("rst_freq", cycles_freq, 32'd0);
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_oe", {31'b0, miso_oe}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    frame(8'h84, 32'h0, 40, 2, rd);
    chk("rd_version", rd, 32'h0001_0000);
    chk("idle_start", {31'b0, start}, 32'd0);
    gap();
    chk("oe_idle", {31'b0, miso_oe}, 32'd0);
    frame(8'h01, 32'd25, 40, 2, rd);
    chk("wr_high_lat", cycles_high, 32'd25);
    gap();
    frame(8'h02, 32'd100, 40, 2, rd);
    chk("wr_freq_lat", cycles_freq, 32'd100);
    gap();
    frame(8'h00, 32'd1, 40, 2, rd);
    chk("wr_ctrl_lat", {31'b0, start}, 32'd1);
    gap();
    frame(8'h81, 32'h0, 40, 2, rd);
    chk("rd_high", rd, 32'd25);
    gap();
    frame(8'h82, 32'h0, 40, 2, rd);
    chk("rd_freq", rd, 32'd100);
    gap();
    frame(8'h80, 32'h0, 40, 2, rd);
    chk("rd_ctrl", rd, 32'd1);
    gap();
    frame(8'h01, 32'hDEAD_BEEF, 20, 2, rd);
    gap();
    chk("abort_high", cycles_high, 32'd25);
    frame(8'h83, 32'h0, 40, 2, rd);
    chk("status_err", rd, 32'd3);
    gap();
    frame(8'h83, 32'h0, 40, 2, rd);
    chk("status_clr", rd, 32'd1);
    gap();
    frame(8'h04, 32'h1234_5678, 40, 2, rd);
    gap();
    frame(8'h84, 32'h0, 40, 2, rd);
    chk("version_ro", rd, 32'h0001_0000);
    gap();
    frame(8'h02, 32'd7, 48, 2, rd);
    gap();
    chk("overrun_freq", cycles_freq, 32'd7);
    frame(8'h83, 32'h0, 40, 2, rd);
    chk("overrun_noerr", rd, 32'd1);
    gap();
    frame(8'h85, 32'h0, 40, 2, rd);
    chk("rd_unmapped", rd, 32'd0);
    gap();
    cs_n = 1'b0;
    #40;
    for (int i = 0; i < 5; i++) begin
      mosi = i[0];
      #20 sclk = 1'b1;
      #20 sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst_start", {31'b0, start}, 32'd0);
    chk("arst_high", cycles_high, 32'd0);
    chk("arst_freq", cycles_freq, 32'd0);
    chk("arst_oe", {31'b0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    #30;
    @(negedge clk);
    rst_n = 1'b1;
    gap();
    frame(8'h00, 32'd1, 40, 2, rd);
    chk("post_rst_start", {31'b0, start}, 32'd1);
    gap();
    chk("post_rst_high", cycles_high, 32'd0);
    #($urandom_range(1, 4));
    frame(8'h01, 32'hA5A5_5A5A, 40, 2, rd);
    chk("phase_wr", cycles_high, 32'hA5A5_5A5A);
    gap();
    #($urandom_range(1, 4));
    frame(8'h81, 32'h0, 40, 2, rd);
    chk("phase_rd", rd, 32'hA5A5_5A5A);
    gap();
    chk("oe_end", {31'b0, miso_oe}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_pwm_regs.md
Name: spi_pwm_regs

Overview:
SPI mode-0 slave register bank that sits directly upstream of the PWM generator. It decodes 40-bit SPI frames into register writes and reads, and drives the generator's start, cycles_high and cycles_freq inputs. All SPI pins are oversampled in the system clock domain; the block contains no sclk-clocked flops.

Parameters:
DATA_W, 32, width of each data register and of the data phase.
CMD_W, 8, command phase width: bit 7 = R/nW, bits 6:0 = address.
VERSION, 32'h0001_0000, constant returned by the VERSION register.

Ports:
clk  input  1  system clock; must be at least 4x the sclk frequency.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock, asynchronous to clk.
cs_n  input  1  SPI chip select, active low, asynchronous.
mosi  input  1  SPI data in, asynchronous.
miso  output  1  SPI data out.
miso_oe  output  1  MISO output enable: 1 while the synchronised cs_n is low.
start  output  1  PWM enable, from CTRL[0].
cycles_high  output  DATA_W  PWM high-time in clk cycles.
cycles_freq  output  DATA_W  PWM period in clk cycles.

Behaviour:
- Reset (async, rst_n=0): start=0, cycles_high=0, cycles_freq=0, miso=0, miso_oe=0, bit counter=0, err flag=0, shift registers=0.
- Synchronisers and edge detect:
  - sclk, cs_n and mosi each pass through a 2-FF synchroniser.
  - A rising edge is sync_sclk=1 with prev=0; a falling edge is the converse.
  - cs_n synchroniser flops reset to 1.
- Frame:
  - Starts when the synchronised cs_n falls; the bit counter clears to 0.
  - Each detected rising edge with cs_n low samples synchronised mosi into the rx shift register, MSB first, and increments the counter (saturating at 40).
- Command phase:
  - On the 8th rising edge, latch cmd = {rx[6:0], mosi_s}.
  - If R/nW=1, load tx shift register = read data of the addressed register in that same cycle.
- Data phase: rising edges 9..40.
  - On the 40th rising edge with R/nW=0, commit the write in that same clk cycle using {rx[30:0], mosi_s}.
  - Outputs show the new value from the next clk edge, so the total latency from the pin edge is at most 4 clk cycles.
- Register map:
  - 0x00 CTRL, RW: bit0=start; other bits read 0.
  - 0x01 CYCLES_HIGH, RW.
  - 0x02 CYCLES_FREQ, RW.
  - 0x03 STATUS, RO: bit0=start, bit1=err. err clears at the clk edge where a STATUS read command is latched.
  - 0x04 VERSION, RO: returns the VERSION parameter.
  - Writes to RO or unmapped addresses are ignored. Reads of unmapped addresses return 0.
- MISO:
  - miso = tx[DATA_W-1] during the data phase of a read, otherwise 0.
  - tx shifts left on each detected falling edge while counter is between 9 and 39 inclusive. The 8th falling edge must not shift, so the MSB stays valid for rising edge 9.
- Abort: if cs_n rises with counter between 1 and 39, discard the frame (no write), set err=1 (sticky), and clear the counter. cs_n rising at exactly 40 is a clean end of frame.
- Overrun: sclk edges beyond 40 in the same frame are ignored: no shift, no second commit.
- Ignored edges: sclk edges while cs_n is high are ignored.
- No sanity checks: writes are not checked for consistency, e.g. cycles_high > cycles_freq is allowed. The downstream generator tolerates it.
- Multi-frame updates: writing CYCLES_HIGH then CYCLES_FREQ takes two frames, and each update is atomic per 32-bit register.
- Reset during a frame returns all state to reset values immediately. The first frame after reset starts only on a fresh cs_n falling edge.

Decomposition:
- Package spi_pwm_pkg holds:
  - address constants ADDR_CTRL/ADDR_HIGH/ADDR_FREQ/ADDR_STATUS/ADDR_VERSION;
  - CMD_W, DATA_W and FRAME_BITS=40;
  - CMD_READ bit index.
- One sub-module: spi_sync_edge, a 2-FF synchroniser plus previous-value flop producing sync, rise and fall pulses. It is instantiated for sclk, and for cs_n with a parameterised reset value of 1. mosi uses sync only.

Test Plan:
- Reset, then read VERSION (cmd 0x84) -> MISO returns 32'h0001_0000 MSB first; all outputs 0.
- Write 0x01 with 32'd25, write 0x02 with 32'd100, write 0x00 with 32'd1 -> cycles_high=25, cycles_freq=100, start=1, each within 4 clk of its 40th sclk rise. Reads of 0x81 and 0x82 return 25 and 100.
- Write 0x01 with 32'hDEAD_BEEF but raise cs_n after 20 bits -> cycles_high unchanged; read STATUS (0x83) returns bit1=1; a second STATUS read returns bit1=0.
- Write 0x04 with 32'h1234_5678, then send a frame with 48 sclk clocks writing 0x02 with 32'd7 -> VERSION unchanged; cycles_freq=7 with exactly one commit.
- Assert rst_n=0 mid-frame after start=1 -> start, cycles_high and cycles_freq are 0 asynchronously. A following full frame writing 0x00 with 1 sets start=1.
- Run sclk at exactly clk/4 with random phase, doing back-to-back write-then-read of 0x01 with 32'hA5A5_5A5A -> readback matches; miso_oe=1 only while cs_n is low.
